// File: rtl/mp_pipe_top.sv
// mp_pipe_top: two-stage pipelined core (decode/read -> execute/writeback)
// with an integrated register file, signed ALU, load-immediate and
// single-cycle operand forwarding so dependent instructions never stall.
module mp_pipe_top #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    input  logic [31:0]       instr,
    output logic [DATA_W-1:0] result,
    output logic              result_valid,
    output logic              illegal,
    output logic [31:0]       retired_count
);

    localparam int unsigned A         = REG_ADDR_W;
    localparam int unsigned REG_COUNT = 1 << REG_ADDR_W;
    localparam int unsigned IMM_W     = 32 - 6 - REG_ADDR_W;
    localparam int unsigned SH_W      = $clog2(DATA_W);

    localparam logic [5:0] OP_NOP = 6'h00;
    localparam logic [5:0] OP_LDI = 6'h01;
    localparam logic [5:0] OP_ADD = 6'h02;
    localparam logic [5:0] OP_SUB = 6'h03;
    localparam logic [5:0] OP_AND = 6'h04;
    localparam logic [5:0] OP_OR  = 6'h05;
    localparam logic [5:0] OP_XOR = 6'h06;
    localparam logic [5:0] OP_SLL = 6'h07;
    localparam logic [5:0] OP_SRL = 6'h08;
    localparam logic [5:0] OP_SRA = 6'h0A;
    localparam logic [5:0] OP_MIN = 6'h0C;
    localparam logic [5:0] OP_MAX = 6'h0D;
    localparam logic [5:0] OP_ABS = 6'h0F;

    // Register file; R0 is never written so it always reads as zero
    logic [DATA_W-1:0] regs [REG_COUNT];

    // Stage S1 state
    logic              s1_valid;
    logic              s1_ill;
    logic [5:0]        s1_op;
    logic [A-1:0]      s1_rd;
    logic [DATA_W-1:0] s1_a;
    logic [DATA_W-1:0] s1_b;

    // Instruction field extraction
    logic [5:0]        op_f;
    logic [A-1:0]      rd_f;
    logic [A-1:0]      rs1_f;
    logic [A-1:0]      rs2_f;
    logic [IMM_W-1:0]  imm_f;
    logic [DATA_W-1:0] imm_ext;

    assign op_f    = instr[5:0];
    assign rd_f    = instr[6 +: A];
    assign rs1_f   = instr[6+A +: A];
    assign rs2_f   = instr[6+2*A +: A];
    assign imm_f   = instr[31:6+A];
    assign imm_ext = DATA_W'($signed(imm_f));

    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] opa;
    logic [DATA_W-1:0] opb;
    logic              is_exec;
    logic              is_ill;
    logic [SH_W-1:0]   sh;

    // Opcode classification: executing (legal, non-NOP), NOP, or illegal
    always_comb begin
        is_exec = 1'b0;
        is_ill  = 1'b0;
        case (op_f)
            OP_NOP: ;
            OP_LDI, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL,
            OP_SRA, OP_MIN, OP_MAX, OP_ABS: is_exec = 1'b1;
            default: is_ill = 1'b1;
        endcase
    end

    // Operand read with forwarding of the in-flight ALU result (never for R0)
    always_comb begin
        opa = regs[rs1_f];
        opb = regs[rs2_f];
        if (s1_valid && (s1_rd == rs1_f) && (rs1_f != '0)) opa = alu;
        if (s1_valid && (s1_rd == rs2_f) && (rs2_f != '0)) opb = alu;
        if (rs1_f == '0) opa = '0;
        if (rs2_f == '0) opb = '0;
    end

    assign sh = s1_b[SH_W-1:0];

    // Signed ALU evaluated from S1
    always_comb begin
        alu = '0;
        case (s1_op)
            OP_LDI: alu = s1_a;
            OP_ADD: alu = s1_a + s1_b;
            OP_SUB: alu = s1_a - s1_b;
            OP_AND: alu = s1_a & s1_b;
            OP_OR:  alu = s1_a | s1_b;
            OP_XOR: alu = s1_a ^ s1_b;
            OP_SLL: alu = s1_a << sh;
            OP_SRL: alu = s1_a >> sh;
            OP_SRA: alu = DATA_W'($signed(s1_a) >>> sh);
            OP_MIN: alu = ($signed(s1_a) < $signed(s1_b)) ? s1_a : s1_b;
            OP_MAX: alu = ($signed(s1_a) > $signed(s1_b)) ? s1_a : s1_b;
            OP_ABS: alu = s1_a[DATA_W-1] ? (DATA_W'(0) - s1_a) : s1_a;
            default: alu = '0;
        endcase
    end

    // S1 capture: decode and operand read; LDI carries its immediate in a
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_ill   <= 1'b0;
            s1_op    <= OP_NOP;
            s1_rd    <= '0;
            s1_a     <= '0;
            s1_b     <= '0;
        end else begin
            s1_valid <= instr_valid && is_exec;
            s1_ill   <= instr_valid && is_ill;
            s1_op    <= op_f;
            s1_rd    <= rd_f;
            s1_a     <= (op_f == OP_LDI) ? imm_ext : opa;
            s1_b     <= opb;
        end
    end

    // Register-file writeback; writes to R0 are discarded
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < REG_COUNT; i++) regs[i] <= '0;
        end else if (s1_valid && (s1_rd != '0)) begin
            regs[s1_rd] <= alu;
        end
    end

    // Retire outputs: result, valid, illegal pulse and retired counter
    always_ff @(posedge clk) begin
        if (rst) begin
            result        <= '0;
            result_valid  <= 1'b0;
            illegal       <= 1'b0;
            retired_count <= '0;
        end else begin
            result_valid <= s1_valid;
            illegal      <= s1_ill;
            if (s1_valid) begin
                result        <= alu;
                retired_count <= retired_count + 32'd1;
            end
        end
    end

endmodule
